// File: rtl/serial_sample_feeder.sv
// I2S left-channel capture into a small FIFO, drained one word per modulator pulse_done.
// Build option SERIAL_FEEDER_TWOS_COMP_EN: convert two's complement input to offset binary on push.
module serial_sample_feeder #(
  parameter int SAMPLE_BITS     = 16,
  parameter int FIFO_DEPTH_LOG2 = 2,
  parameter int SYNC_STAGES     = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       sck_in,
  input  logic                       ws_in,
  input  logic                       sd_in,
  input  logic                       pulse_done,
  input  logic                       clear_flags,
  output logic [SAMPLE_BITS-1:0]     sample_out,
  output logic [FIFO_DEPTH_LOG2:0]   fifo_level,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
  localparam int CNT_W = $clog2(SAMPLE_BITS + 1);
  localparam logic [SAMPLE_BITS-1:0] MSB_MASK = {1'b1, {(SAMPLE_BITS-1){1'b0}}};
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(SAMPLE_BITS - 1);
  localparam logic [FIFO_DEPTH_LOG2:0] FULL_LEVEL = {1'b1, {FIFO_DEPTH_LOG2{1'b0}}};

  typedef enum logic [1:0] {IDLE, SKIP, SHIFT} state_t;

  // sck, ws and sd share one chain so they stay mutually aligned
  logic [2:0] sync_reg [SYNC_STAGES];

  genvar gi;
  generate
    for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
      if (gi == 0) begin : g_first
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) sync_reg[gi] <= '0;
          else        sync_reg[gi] <= {sck_in, ws_in, sd_in};
        end
      end else begin : g_next
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) sync_reg[gi] <= '0;
          else        sync_reg[gi] <= sync_reg[gi-1];
        end
      end
    end
  endgenerate

  logic sck_sync, ws_sync, sd_sync;
  assign {sck_sync, ws_sync, sd_sync} = sync_reg[SYNC_STAGES-1];

  logic                   sck_prev_reg;
  logic                   ws_last_reg;
  state_t                 state_reg;
  logic [CNT_W-1:0]       bit_cnt_reg;
  logic [SAMPLE_BITS-1:0] word_reg;

  logic                   sck_rise;
  logic                   ws_change;
  logic [SAMPLE_BITS-1:0] word_next;
  logic [SAMPLE_BITS-1:0] push_raw;
  logic [SAMPLE_BITS-1:0] push_data;
  logic                   push;

  assign sck_rise  = sck_sync & ~sck_prev_reg;
  assign ws_change = sck_rise & (ws_sync != ws_last_reg);

  // word is cleared before capture, so a short word is already zero-padded
  always_comb begin
    word_next = word_reg | (sd_sync ? (MSB_MASK >> bit_cnt_reg) : '0);
    push_raw  = word_reg;
    push      = 1'b0;
    if (sck_rise && state_reg == SHIFT) begin
      if (ws_change) begin
        push     = 1'b1;
        push_raw = word_reg;
      end else if (bit_cnt_reg == LAST_BIT) begin
        push     = 1'b1;
        push_raw = word_next;
      end
    end
  end

`ifdef SERIAL_FEEDER_TWOS_COMP_EN
  assign push_data = push_raw ^ MSB_MASK;
`else
  assign push_data = push_raw;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_prev_reg <= 1'b0;
      ws_last_reg  <= 1'b0;
      state_reg    <= IDLE;
      bit_cnt_reg  <= '0;
      word_reg     <= '0;
    end else begin
      sck_prev_reg <= sck_sync;
      if (sck_rise) begin
        ws_last_reg <= ws_sync;
        if (ws_change) begin
          state_reg <= ws_sync ? IDLE : SKIP;
        end else begin
          case (state_reg)
            SKIP: begin
              state_reg   <= SHIFT;
              bit_cnt_reg <= '0;
              word_reg    <= '0;
            end
            SHIFT: begin
              word_reg    <= word_next;
              bit_cnt_reg <= bit_cnt_reg + 1'b1;
              if (bit_cnt_reg == LAST_BIT) state_reg <= IDLE;
            end
            default: state_reg <= IDLE;
          endcase
        end
      end
    end
  end

  logic [SAMPLE_BITS-1:0]     mem [DEPTH];
  logic [FIFO_DEPTH_LOG2:0]   wr_ptr_reg;
  logic [FIFO_DEPTH_LOG2:0]   rd_ptr_reg;
  logic [FIFO_DEPTH_LOG2:0]   level;
  logic                       full;
  logic                       empty;
  logic                       pop_ok;
  logic                       push_ok;
  logic [SAMPLE_BITS-1:0]     sample_out_reg;
  logic                       overflow_reg;
  logic                       underflow_reg;

  assign level   = wr_ptr_reg - rd_ptr_reg;
  assign full    = (level == FULL_LEVEL);
  assign empty   = (level == '0);
  assign pop_ok  = pulse_done & ~empty;
  // a pop in the same cycle frees the slot the push needs
  assign push_ok = push & (~full | pop_ok);

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_reg[FIFO_DEPTH_LOG2-1:0]] <= push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      sample_out_reg <= MSB_MASK;
      overflow_reg   <= 1'b0;
      underflow_reg  <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop_ok) begin
        rd_ptr_reg     <= rd_ptr_reg + 1'b1;
        sample_out_reg <= mem[rd_ptr_reg[FIFO_DEPTH_LOG2-1:0]];
      end
      overflow_reg  <= (push & ~push_ok) | (overflow_reg & ~clear_flags);
      underflow_reg <= (pulse_done & empty) | (underflow_reg & ~clear_flags);
    end
  end

  assign sample_out = sample_out_reg;
  assign fifo_level = level;
  assign overflow   = overflow_reg;
  assign underflow  = underflow_reg;

endmodule

// File: tb/tb_serial_sample_feeder.sv
// Directed bench for serial_sample_feeder: vector table of serial/pop/clear steps plus corner sequences.
module tb_serial_sample_feeder;

  localparam int SB   = 16;
  localparam int SYNC = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sck_in = 1'b0;
  logic        ws_in = 1'b0;
  logic        sd_in = 1'b0;
  logic        pulse_done = 1'b0;
  logic        clear_flags = 1'b0;
  logic [15:0] sample_out;
  logic [2:0]  fifo_level;
  logic        overflow;
  logic        underflow;

  int n_total = 0;
  int n_pass  = 0;

  serial_sample_feeder #(
    .SAMPLE_BITS(SB),
    .FIFO_DEPTH_LOG2(2),
    .SYNC_STAGES(SYNC)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .sck_in(sck_in),
    .ws_in(ws_in),
    .sd_in(sd_in),
    .pulse_done(pulse_done),
    .clear_flags(clear_flags),
    .sample_out(sample_out),
    .fifo_level(fifo_level),
    .overflow(overflow),
    .underflow(underflow)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef enum int {OP_RST, OP_POP, OP_CLR, OP_SEND, OP_RIGHT} op_t;

  typedef struct {
    op_t         op;
    logic [15:0] data;
    int          nbits;
    logic [2:0]  exp_level;
    logic [15:0] exp_sample;
    logic        exp_ovf;
    logic        exp_unf;
  } vec_t;

  vec_t vq[$];

  function automatic logic [15:0] cv(input logic [15:0] x);
`ifdef SERIAL_FEEDER_TWOS_COMP_EN
    return x ^ 16'h8000;
`else
    return x;
`endif
  endfunction

  function automatic void add(input op_t op, input logic [15:0] data, input int nbits,
                              input logic [2:0] lvl, input logic [15:0] smp,
                              input logic ovf, input logic unf);
    vec_t v;
    v.op = op; v.data = data; v.nbits = nbits;
    v.exp_level = lvl; v.exp_sample = smp; v.exp_ovf = ovf; v.exp_unf = unf;
    vq.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic check_all(input string tag, input logic [2:0] lvl, input logic [15:0] smp,
                           input logic ovf, input logic unf);
    chk({tag, " level"}, 32'(fifo_level), 32'(lvl));
    chk({tag, " sample"}, 32'(sample_out), 32'(smp));
    chk({tag, " overflow"}, 32'(overflow), 32'(ovf));
    chk({tag, " underflow"}, 32'(underflow), 32'(unf));
  endtask

  // Called at a negedge; returns at a negedge. Optionally pops in the clk
  // cycle where the synchronised rising edge of this bit is seen.
  task automatic send_bit(input logic w, input logic d, input bit pop_at_rise);
    sck_in = 1'b0; ws_in = w; sd_in = d;
    repeat (8) @(negedge clk);
    sck_in = 1'b1;
    if (pop_at_rise) begin
      repeat (SYNC) @(negedge clk);
      pulse_done = 1'b1;
      @(negedge clk);
      pulse_done = 1'b0;
      repeat (8 - SYNC - 1) @(negedge clk);
    end else begin
      repeat (8) @(negedge clk);
    end
  endtask

  task automatic send_right(input logic [15:0] word);
    for (int i = 0; i < 18; i++) send_bit(1'b1, (i < 16) ? word[15-i] : 1'b0, 1'b0);
  endtask

  // delay bit, skipped bit, nbits of data, then ws back high for one bit
  task automatic send_left(input logic [15:0] word, input int nbits, input bit pop_last);
    send_bit(1'b0, 1'b0, 1'b0);
    send_bit(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < nbits; i++) send_bit(1'b0, word[15-i], pop_last && (i == nbits - 1));
    send_bit(1'b1, 1'b1, 1'b0);
  endtask

  task automatic send_frame(input logic [15:0] word, input int nbits, input bit pop_last);
    send_right(16'hFFFF);
    send_left(word, nbits, pop_last);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; sck_in = 1'b0; ws_in = 1'b0; sd_in = 1'b0;
    pulse_done = 1'b0; clear_flags = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic strobe(input logic p, input logic c);
    pulse_done = p; clear_flags = c;
    @(negedge clk);
    pulse_done = 1'b0; clear_flags = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    string tag;

    add(OP_RST,   16'h0000,  0, 3'd0, 16'h8000,      1'b0, 1'b0);
    add(OP_POP,   16'h0000,  0, 3'd0, 16'h8000,      1'b0, 1'b1);
    add(OP_CLR,   16'h0000,  0, 3'd0, 16'h8000,      1'b0, 1'b0);
    add(OP_SEND,  16'h1234, 16, 3'd1, 16'h8000,      1'b0, 1'b0);
    add(OP_POP,   16'h0000,  0, 3'd0, cv(16'h1234),  1'b0, 1'b0);
    add(OP_SEND,  16'h0001, 16, 3'd1, cv(16'h1234),  1'b0, 1'b0);
    add(OP_SEND,  16'h0002, 16, 3'd2, cv(16'h1234),  1'b0, 1'b0);
    add(OP_SEND,  16'h0003, 16, 3'd3, cv(16'h1234),  1'b0, 1'b0);
    add(OP_SEND,  16'h0004, 16, 3'd4, cv(16'h1234),  1'b0, 1'b0);
    add(OP_SEND,  16'h0005, 16, 3'd4, cv(16'h1234),  1'b1, 1'b0);
    add(OP_POP,   16'h0000,  0, 3'd3, cv(16'h0001),  1'b1, 1'b0);
    add(OP_POP,   16'h0000,  0, 3'd2, cv(16'h0002),  1'b1, 1'b0);
    add(OP_POP,   16'h0000,  0, 3'd1, cv(16'h0003),  1'b1, 1'b0);
    add(OP_POP,   16'h0000,  0, 3'd0, cv(16'h0004),  1'b1, 1'b0);
    add(OP_CLR,   16'h0000,  0, 3'd0, cv(16'h0004),  1'b0, 1'b0);
    add(OP_SEND,  16'hAB00,  8, 3'd1, cv(16'h0004),  1'b0, 1'b0);
    add(OP_SEND,  16'h1357, 16, 3'd2, cv(16'h0004),  1'b0, 1'b0);
    add(OP_POP,   16'h0000,  0, 3'd1, cv(16'hAB00),  1'b0, 1'b0);
    add(OP_POP,   16'h0000,  0, 3'd0, cv(16'h1357),  1'b0, 1'b0);
    add(OP_RIGHT, 16'hFFFF,  0, 3'd0, cv(16'h1357),  1'b0, 1'b0);
    add(OP_RST,   16'h0000,  0, 3'd0, 16'h8000,      1'b0, 1'b0);

    @(negedge clk);
    for (int i = 0; i < vq.size(); i++) begin
      case (vq[i].op)
        OP_RST:   do_reset();
        OP_POP:   strobe(1'b1, 1'b0);
        OP_CLR:   strobe(1'b0, 1'b1);
        OP_SEND:  send_frame(vq[i].data, vq[i].nbits, 1'b0);
        OP_RIGHT: send_right(vq[i].data);
        default:  ;
      endcase
      repeat (2) @(negedge clk);
      tag = $sformatf("vec%0d", i);
      check_all(tag, vq[i].exp_level, vq[i].exp_sample, vq[i].exp_ovf, vq[i].exp_unf);
      $display("vec %0d op=%0d data=0x%04h level=%0d sample=0x%04h ovf=%0b unf=%0b",
               i, vq[i].op, vq[i].data, fifo_level, sample_out, overflow, underflow);
    end

    // Full FIFO: a pop coincides with the push of the fifth word
    do_reset();
    for (int i = 1; i <= 4; i++) send_frame(16'h0A00 + 16'(i), 16, 1'b0);
    repeat (2) @(negedge clk);
    chk("full_before level", 32'(fifo_level), 32'd4);
    send_frame(16'h0A05, 16, 1'b1);
    repeat (2) @(negedge clk);
    check_all("push_pop_full", 3'd4, cv(16'h0A01), 1'b0, 1'b0);
    $display("push+pop on full: level=%0d sample=0x%04h ovf=%0b", fifo_level, sample_out, overflow);
    for (int i = 2; i <= 5; i++) begin
      pulse_done = 1'b1;
      @(negedge clk);
      pulse_done = 1'b0;
      tag = $sformatf("drain%0d", i);
      chk({tag, " sample"}, 32'(sample_out), 32'(cv(16'h0A00 + 16'(i))));
      chk({tag, " level"}, 32'(fifo_level), 32'(5 - i));
      $display("drain pop %0d: sample=0x%04h level=%0d", i, sample_out, fifo_level);
      @(negedge clk);
    end

    // clear_flags together with an underflowing pop: set wins
    strobe(1'b1, 1'b0);
    chk("unf_set underflow", 32'(underflow), 32'd1);
    strobe(1'b1, 1'b1);
    chk("clr_vs_unf underflow", 32'(underflow), 32'd1);
    chk("clr_vs_unf sample", 32'(sample_out), 32'(cv(16'h0A05)));
    strobe(1'b0, 1'b1);
    chk("clr_only underflow", 32'(underflow), 32'd0);
    $display("clear vs underflow: unf=%0b sample=0x%04h", underflow, sample_out);

    // Reset in the middle of a left word, then a clean word
    send_right(16'hFFFF);
    send_bit(1'b0, 1'b0, 1'b0);
    send_bit(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) send_bit(1'b0, 1'b1, 1'b0);
    do_reset();
    check_all("midword_rst", 3'd0, 16'h8000, 1'b0, 1'b0);
    send_frame(16'h5555, 16, 1'b0);
    repeat (2) @(negedge clk);
    chk("after_rst level", 32'(fifo_level), 32'd1);
    strobe(1'b1, 1'b0);
    check_all("after_rst pop", 3'd0, cv(16'h5555), 1'b0, 1'b0);
    $display("mid-word reset then 0x5555: sample=0x%04h level=%0d", sample_out, fifo_level);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
